// File: rtl/grid_pkg.sv
// Shared grid definitions: cell status encodings, address width and the
// read-response owner tags used by the grid memory arbiter.
package grid_pkg;

  localparam int GRID_ADDR_W = 8;

  localparam logic [1:0] GRID_STATUS_EMPTY  = 2'b00;
  localparam logic [1:0] GRID_STATUS_MYSHIP = 2'b01;
  localparam logic [1:0] GRID_STATUS_MISS   = 2'b10;
  localparam logic [1:0] GRID_STATUS_HIT    = 2'b11;

  localparam logic [GRID_ADDR_W-1:0] GRID_NONE = 8'hff;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_FSM  = 2'd1,
    TAG_DISP = 2'd2
  } owner_tag_t;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/grid_mem_arbiter_if.sv
// Bundle of the clear, FSM, display and RAM-side signals around one grid
// memory arbiter; slave is the arbiter's view, master the surrounding logic.
interface grid_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 2
);
  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;

  logic              fsm_req;
  logic              fsm_w_nr;
  logic [ADDR_W-1:0] fsm_addr;
  logic [DATA_W-1:0] fsm_wdata;
  logic              fsm_gnt;
  logic              fsm_rvalid;
  logic [DATA_W-1:0] fsm_rdata;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  clear_req, fsm_req, fsm_w_nr, fsm_addr, fsm_wdata,
           disp_req, disp_addr, ram_rdata,
    output clear_busy, clear_done, fsm_gnt, fsm_rvalid, fsm_rdata,
           disp_gnt, disp_rvalid, disp_rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output clear_req, fsm_req, fsm_w_nr, fsm_addr, fsm_wdata,
           disp_req, disp_addr, ram_rdata,
    input  clear_busy, clear_done, fsm_gnt, fsm_rvalid, fsm_rdata,
           disp_gnt, disp_rvalid, disp_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/grid_mem_arbiter.sv
// Single-port grid RAM arbiter: FSM has priority with a bounded burst before
// the display gets a slot; also sequences a full-grid wipe to EMPTY.
//
// state    | meaning
// ST_ARB   | grant FSM/display accesses, one per cycle
// ST_CLEAR | write EMPTY to every address, then pulse clear_done
module grid_mem_arbiter
  import grid_pkg::*;
#(
  parameter int ADDR_W    = GRID_ADDR_W,
  parameter int DATA_W    = 2,
  parameter int FSM_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  grid_mem_arbiter_if.slave  bus
);

  localparam int                 BURST_W   = $clog2(FSM_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(FSM_BURST);
  localparam logic [ADDR_W:0]    CLR_END   = {1'b1, {ADDR_W{1'b0}}};

  arb_state_t        state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  owner_tag_t        tag1_q, tag1_d, tag2_q;
  logic              fsm_rvalid_q, fsm_rvalid_d;
  logic [DATA_W-1:0] fsm_rdata_q, fsm_rdata_d;
  logic              disp_rvalid_q, disp_rvalid_d;
  logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
  logic              fsm_gnt, disp_gnt, clear_busy, clear_done;

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    clr_cnt_d   = clr_cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    tag1_d      = TAG_NONE;
    fsm_gnt     = 1'b0;
    disp_gnt    = 1'b0;
    clear_busy  = 1'b0;
    clear_done  = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (bus.clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (bus.fsm_req && bus.disp_req && burst_q == BURST_MAX) begin
          disp_gnt = 1'b1;
          burst_d  = '0;
        end else if (bus.fsm_req) begin
          fsm_gnt = 1'b1;
          if (!bus.disp_req)
            burst_d = '0;
          else if (burst_q != BURST_MAX)
            burst_d = burst_q + BURST_W'(1);
        end else if (bus.disp_req) begin
          disp_gnt = 1'b1;
          burst_d  = '0;
        end

        if (fsm_gnt) begin
          ram_addr_d  = bus.fsm_addr;
          ram_we_d    = bus.fsm_w_nr;
          ram_wdata_d = bus.fsm_wdata;
          tag1_d      = bus.fsm_w_nr ? TAG_NONE : TAG_FSM;
        end else if (disp_gnt) begin
          ram_addr_d = bus.disp_addr;
          tag1_d     = TAG_DISP;
        end
      end

      ST_CLEAR: begin
        // Counter runs one past the last address so the done cycle is distinct
        if (clr_cnt_q == CLR_END) begin
          clear_done = 1'b1;
          state_d    = ST_ARB;
          clr_cnt_d  = '0;
        end else begin
          clear_busy  = 1'b1;
          ram_addr_d  = clr_cnt_q[ADDR_W-1:0];
          ram_we_d    = 1'b1;
          ram_wdata_d = DATA_W'(GRID_STATUS_EMPTY);
          clr_cnt_d   = clr_cnt_q + (ADDR_W+1)'(1);
        end
      end

      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    fsm_rvalid_d  = (tag2_q == TAG_FSM);
    disp_rvalid_d = (tag2_q == TAG_DISP);
    fsm_rdata_d   = (tag2_q == TAG_FSM)  ? bus.ram_rdata : fsm_rdata_q;
    disp_rdata_d  = (tag2_q == TAG_DISP) ? bus.ram_rdata : disp_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ARB;
      burst_q       <= '0;
      clr_cnt_q     <= '0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      tag1_q        <= TAG_NONE;
      tag2_q        <= TAG_NONE;
      fsm_rvalid_q  <= 1'b0;
      fsm_rdata_q   <= '0;
      disp_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      burst_q       <= burst_d;
      clr_cnt_q     <= clr_cnt_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      tag1_q        <= tag1_d;
      tag2_q        <= tag1_q;
      fsm_rvalid_q  <= fsm_rvalid_d;
      fsm_rdata_q   <= fsm_rdata_d;
      disp_rvalid_q <= disp_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
    end
  end

  assign bus.clear_busy  = clear_busy;
  assign bus.clear_done  = clear_done;
  assign bus.fsm_gnt     = fsm_gnt;
  assign bus.fsm_rvalid  = fsm_rvalid_q;
  assign bus.fsm_rdata   = fsm_rdata_q;
  assign bus.disp_gnt    = disp_gnt;
  assign bus.disp_rvalid = disp_rvalid_q;
  assign bus.disp_rdata  = disp_rdata_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Self-checking bench for grid_mem_arbiter: RAM model plus a shadow grid and
// per-owner scoreboard queues checking read data and latency.
module tb_grid_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    logic [1:0] data;
    int         cyc;
  } exp_t;

  exp_t       fsm_q[$];
  exp_t       disp_q[$];
  logic [1:0] shadow[256];
  logic [1:0] mem[256];

  grid_mem_arbiter_if #(.ADDR_W(8), .DATA_W(2)) bus ();

  grid_mem_arbiter #(.ADDR_W(8), .DATA_W(2), .FSM_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous write, registered read one cycle after address
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // Scoreboard: push expectations at grant, pop and compare at rvalid
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fsm_gnt) begin
        if (bus.fsm_w_nr) shadow[bus.fsm_addr] = bus.fsm_wdata;
        else fsm_q.push_back('{shadow[bus.fsm_addr], cyc + 3});
      end
      if (bus.disp_gnt) disp_q.push_back('{shadow[bus.disp_addr], cyc + 3});
      if (bus.fsm_rvalid) begin
        n_tests++;
        if (fsm_q.size() == 0) begin
          n_fail++;
          $display("FAIL fsm_rvalid_unexpected: got rvalid at cycle %0d, required none", cyc);
        end else begin
          exp_t e;
          e = fsm_q.pop_front();
          if (bus.fsm_rdata !== e.data || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL fsm_read: got data %b at cycle %0d, required %b at cycle %0d",
                     bus.fsm_rdata, cyc, e.data, e.cyc);
          end
        end
      end
      if (bus.disp_rvalid) begin
        n_tests++;
        if (disp_q.size() == 0) begin
          n_fail++;
          $display("FAIL disp_rvalid_unexpected: got rvalid at cycle %0d, required none", cyc);
        end else begin
          exp_t e;
          e = disp_q.pop_front();
          if (bus.disp_rdata !== e.data || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL disp_read: got data %b at cycle %0d, required %b at cycle %0d",
                     bus.disp_rdata, cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    bus.clear_req = 1'b0;
    bus.fsm_req   = 1'b0;
    bus.disp_req  = 1'b0;
  endtask

  task automatic fsm_access(input bit w, input logic [7:0] a, input logic [1:0] d);
    int t = 0;
    @(posedge clk); #1;
    bus.fsm_req = 1'b1; bus.fsm_w_nr = w; bus.fsm_addr = a; bus.fsm_wdata = d;
    @(negedge clk);
    while (!bus.fsm_gnt && t < 20) begin @(negedge clk); t++; end
    n_tests++;
    if (bus.fsm_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL fsm_access_grant: got fsm_gnt %b, required 1 (addr %h)", bus.fsm_gnt, a);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((fsm_q.size() != 0 || disp_q.size() != 0) && t < 50) begin
      @(negedge clk); t++;
    end
    n_tests++;
    if (fsm_q.size() != 0 || disp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d fsm / %0d disp responses outstanding, required 0",
               fsm_q.size(), disp_q.size());
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    n_tests++;
    if ({bus.clear_busy, bus.clear_done, bus.fsm_gnt, bus.fsm_rvalid, bus.fsm_rdata,
         bus.disp_gnt, bus.disp_rvalid, bus.disp_rdata, bus.ram_addr, bus.ram_we,
         bus.ram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs busy=%b done=%b fg=%b fv=%b dg=%b dv=%b addr=%h we=%b, required all 0",
               tag, bus.clear_busy, bus.clear_done, bus.fsm_gnt, bus.fsm_rvalid,
               bus.disp_gnt, bus.disp_rvalid, bus.ram_addr, bus.ram_we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    check_outputs_zero("reset_async");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_release");
  endtask

  task automatic run_clear(input bit with_fsm, input bit second_req, input bit pre_read);
    int  nw = 0;
    int  c0;
    int  cnt = 0;
    bit  done = 1'b0;
    if (pre_read) begin
      @(posedge clk); #1;
      bus.fsm_req = 1'b1; bus.fsm_w_nr = 1'b0; bus.fsm_addr = 8'h23;
      @(negedge clk);
      n_tests++;
      if (bus.fsm_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL pre_clear_read_grant: got %b, required 1", bus.fsm_gnt);
      end
    end
    @(posedge clk); #1;
    bus.clear_req = 1'b1;
    bus.fsm_req   = with_fsm;
    bus.fsm_w_nr  = 1'b1; bus.fsm_addr = 8'h40; bus.fsm_wdata = 2'b10;
    c0 = cyc;
    @(negedge clk);
    n_tests++;
    if (bus.fsm_gnt !== 1'b0 || bus.disp_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_wins: got fsm_gnt %b disp_gnt %b, required 0 0", bus.fsm_gnt, bus.disp_gnt);
    end
    while (!done && cnt < 400) begin
      @(posedge clk); #1;
      bus.clear_req = (second_req && cnt == 100);
      cnt++;
      @(negedge clk);
      if (bus.ram_we) begin
        n_tests++;
        if (bus.ram_addr !== nw[7:0] || bus.ram_wdata !== 2'b00) begin
          n_fail++;
          $display("FAIL clear_write: got addr %h data %b, required addr %h data 00",
                   bus.ram_addr, bus.ram_wdata, nw[7:0]);
        end
        nw++;
      end
      if (with_fsm) begin
        n_tests++;
        if (bus.fsm_gnt !== 1'b0) begin
          n_fail++;
          $display("FAIL clear_fsm_blocked: got fsm_gnt %b at cycle %0d, required 0", bus.fsm_gnt, cyc);
        end
      end
      if (bus.clear_done === 1'b1) begin
        done = 1'b1;
        bus.fsm_req = 1'b0;
        n_tests++;
        if (cyc - c0 != 257 || bus.clear_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL clear_done_timing: got %0d cycles busy %b, required 257 cycles busy 0",
                   cyc - c0, bus.clear_busy);
        end
      end else begin
        n_tests++;
        if (bus.clear_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL clear_busy: got %b at cycle %0d, required 1", bus.clear_busy, cyc);
        end
      end
    end
    bus.fsm_req = 1'b0;
    bus.clear_req = 1'b0;
    n_tests++;
    if (!done || nw != 256) begin
      n_fail++;
      $display("FAIL clear_count: got done %b with %0d writes, required done 1 with 256 writes", done, nw);
    end
    @(negedge clk);
    n_tests++;
    if (bus.clear_done !== 1'b0 || bus.ram_we !== 1'b0 || bus.clear_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_after: got done %b we %b busy %b, required 0 0 0",
               bus.clear_done, bus.ram_we, bus.clear_busy);
    end
    for (int i = 0; i < 256; i++) shadow[i] = 2'b00;
    drain();
  endtask

  task automatic test_fsm_rw();
    fsm_access(1'b1, 8'h23, 2'b01);
    fsm_access(1'b0, 8'h23, 2'b00);
    idle();
    drain();
    // FSM held high with display idle is granted every cycle
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.fsm_req = 1'b1; bus.fsm_w_nr = 1'b0; bus.fsm_addr = 8'(8'h20 + i);
      @(negedge clk);
      n_tests++;
      if (bus.fsm_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL fsm_hold_grant: got %b on cycle %0d, required 1", bus.fsm_gnt, i);
      end
    end
    idle();
    drain();
  endtask

  task automatic test_burst();
    logic [7:0] da = 8'h00;
    bit         exp_d;
    for (int i = 0; i < 16; i++) fsm_access(1'b1, 8'(i), 2'(i % 4));
    idle();
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      bus.fsm_req = 1'b1; bus.fsm_w_nr = 1'b0; bus.fsm_addr = (i % 2 != 0) ? 8'h03 : 8'h06;
      bus.disp_req = 1'b1; bus.disp_addr = da;
      @(negedge clk);
      exp_d = (i % 5 == 4);
      n_tests++;
      if (bus.disp_gnt !== exp_d || bus.fsm_gnt !== !exp_d) begin
        n_fail++;
        $display("FAIL burst_pattern: slot %0d got fsm %b disp %b, required fsm %b disp %b",
                 i, bus.fsm_gnt, bus.disp_gnt, !exp_d, exp_d);
      end
      if (bus.disp_gnt) da++;
    end
    idle();
    drain();
  endtask

  task automatic test_stream();
    int k = 0;
    int cnt = 0;
    bit wrote = 1'b0;
    while (k < 10 && cnt < 50) begin
      @(posedge clk); #1;
      bus.disp_req = 1'b1; bus.disp_addr = 8'(k);
      bus.fsm_req = (k == 3 && !wrote);
      bus.fsm_w_nr = 1'b1; bus.fsm_addr = 8'h05; bus.fsm_wdata = 2'b11;
      @(negedge clk);
      n_tests++;
      if (bus.fsm_req) begin
        wrote = 1'b1;
        if (bus.fsm_gnt !== 1'b1 || bus.disp_gnt !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_stall: got fsm %b disp %b, required fsm 1 disp 0", bus.fsm_gnt, bus.disp_gnt);
        end
      end else if (bus.disp_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_grant: addr %0d got disp_gnt %b, required 1", k, bus.disp_gnt);
      end
      if (bus.disp_gnt) k++;
      cnt++;
    end
    idle();
    fsm_access(1'b0, 8'h05, 2'b00);
    idle();
    drain();
  endtask

  task automatic test_reset_mid_clear();
    int t = 0;
    @(posedge clk); #1; bus.clear_req = 1'b1;
    @(posedge clk); #1; bus.clear_req = 1'b0;
    @(negedge clk);
    while (!(bus.ram_we === 1'b1 && bus.ram_addr === 8'h80) && t < 400) begin
      @(negedge clk); t++;
    end
    n_tests++;
    if (bus.ram_addr !== 8'h80) begin
      n_fail++;
      $display("FAIL reach_clear_80: got addr %h, required 80", bus.ram_addr);
    end
    #2 rst = 1'b1;
    #1 check_outputs_zero("reset_mid_clear");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.clear_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done: got clear_done %b, required 0", bus.clear_done);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_mid_clear_release");
    run_clear(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.clear_req = 1'b0;
    bus.fsm_req   = 1'b0;
    bus.fsm_w_nr  = 1'b0;
    bus.fsm_addr  = '0;
    bus.fsm_wdata = '0;
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    test_reset();
    run_clear(1'b0, 1'b0, 1'b0);
    test_fsm_rw();
    test_burst();
    test_stream();
    run_clear(1'b1, 1'b1, 1'b1);
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/grid_mem_arbiter.md
Name: grid_mem_arbiter

Overview:
Shares one single-port grid RAM (256 x 2-bit cell status) between the game FSM (read/write, high priority) and the display pixel pipeline (read-only stream). It also contains a clear sequencer that wipes the whole grid to EMPTY before a new game. One instance sits in front of each grid memory (own and enemy board).

Parameters:
ADDR_W, 8, grid address width; depth = 2**ADDR_W
DATA_W, 2, cell status width
FSM_BURST, 4, max consecutive FSM grants while display is requesting before one display grant is forced

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
clear_req  in  1  pulse: start grid wipe
clear_busy  out  1  high while wipe in progress
clear_done  out  1  one-cycle pulse after last wipe write
fsm_req  in  1  FSM access request (level, sampled each cycle)
fsm_w_nr  in  1  1 = write, 0 = read
fsm_addr  in  ADDR_W  FSM cell address
fsm_wdata  in  DATA_W  FSM write data
fsm_gnt  out  1  combinational: FSM access accepted this cycle
fsm_rvalid  out  1  one-cycle pulse: fsm_rdata valid
fsm_rdata  out  DATA_W  FSM read data, held until next fsm_rvalid
disp_req  in  1  display read request
disp_addr  in  ADDR_W  display cell address
disp_gnt  out  1  combinational: display read accepted this cycle
disp_rvalid  out  1  one-cycle pulse: disp_rdata valid
disp_rdata  out  DATA_W  display read data, held until next disp_rvalid
ram_addr  out  ADDR_W  registered RAM address
ram_we  out  1  registered RAM write enable
ram_wdata  out  DATA_W  registered RAM write data
ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_addr

Behaviour:
- Reset: state ARB; all outputs 0; burst counter 0; clear counter 0; read tag pipeline empty.
- States: ARB, CLEAR.
- ARB grant rules, cycle N, evaluated in order:
  - clear_req = 1: go to CLEAR; no grants in N.
  - fsm_req and disp_req both high and burst counter = FSM_BURST: disp_gnt; counter cleared.
  - fsm_req high: fsm_gnt; counter increments (saturating) if disp_req, else cleared.
  - disp_req high: disp_gnt; counter cleared.
- Grant cycle N: ram_addr/ram_we/ram_wdata are loaded at the end of N (visible in N+1). Display grants always load ram_we = 0.
  - Write: RAM writes in N+1. No read response.
  - Read: owner tag enters a 2-stage pipeline. ram_rdata is valid in N+2 and registered into the owner's rdata. Owner's rvalid pulses in N+3.
- No request in ARB: ram_we = 0 next cycle; ram_addr holds.
- Throughput: one access per cycle; read responses return in issue order, one per cycle max.
- CLEAR:
  - clear_busy = 1; fsm_gnt = disp_gnt = 0.
  - Writes EMPTY (2'b00) to addr 0..2**ADDR_W-1, one per cycle, with clear counter ADDR_W+1 bits wide.
  - The cycle after the last address is loaded: ram_we = 0, clear_done pulses, return to ARB, clear_busy = 0.
- Boundaries:
  - clear_req while in CLEAR is ignored.
  - clear_req with fsm_req in the same cycle: clear wins, FSM stays ungranted.
  - Reads issued before entering CLEAR still complete their rvalid.
  - Address wrap is not used; the counter terminates at depth.
  - fsm_req held high with disp_req idle never blocks the FSM.
  - Async rst mid-CLEAR aborts immediately, with no clear_done; memory content is undefined.

Decomposition:
- Shared package grid_pkg: GRID_STATUS_EMPTY/MYSHIP/MISS/HIT (2'b00/01/10/11), GRID_ADDR_W = 8, GRID_NONE = 8'hff, and an owner-tag typedef (TAG_NONE, TAG_FSM, TAG_DISP).
- Arbiter, clear sequencer and response pipeline stay in one module. No sub-module needed.

Test Plan:
- Reset, then clear_req → 256 consecutive ram_we with addr 0x00..0xFF and wdata 0; clear_done exactly 257 cycles after clear_req; clear_busy high throughout.
- FSM write addr 0x23 data 2'b01, then FSM read 0x23 (RAM model) → fsm_rvalid 3 cycles after read grant, fsm_rdata = 2'b01.
- disp_req and fsm_req held high, alternating read addresses → grant pattern F,F,F,F,D repeating; every disp_rvalid carries the correct data.
- Display streams addr 0..9, FSM writes 0x05 = 2'b11 mid-stream → display stalls one cycle; later read of 0x05 returns 2'b11; all responses stay in order.
- clear_req asserted with fsm_req the same cycle, and again mid-CLEAR → fsm_gnt = 0 until clear_done; second clear_req causes no restart (still 256 writes).
- rst asserted at clear address 0x80 → outputs 0 asynchronously, state ARB, no clear_done; a new clear_req completes normally.
